// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared types and helpers for the enigma stream driver and its output FIFO.
//   state_t        : driver FSM states (ST_GAP is only reached when GROUP5_EN
//                    is defined)
//   letter_t       : 5-bit letter code, 1..26 for 'A'..'Z'
//   ASCII_*        : byte constants used when building output characters
//   is_letter()    : true for 'A'-'Z' and 'a'-'z'
//   letter_code()  : ASCII letter -> 1..26 code (either case)
//   code_to_ascii(): 1..26 code -> uppercase ASCII
// -----------------------------------------------------------------------------
package enigma_pkg;

    typedef enum logic [2:0] {
        ST_UNCONF = 3'd0,
        ST_CONFIG = 3'd1,
        ST_IDLE   = 3'd2,
        ST_SEND   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    typedef logic [4:0] letter_t;

    localparam logic [7:0] ASCII_A_BASE = 8'h40;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_QMARK  = 8'h3F;

    // Letters per output group when grouping is enabled.
    localparam int GROUP_LEN = 5;

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) ||
               ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Upper and lower case share the low five bits, so masking yields 1..26.
    function automatic letter_t letter_code(input logic [7:0] b);
        logic [7:0] masked;
        masked = b & 8'h1F;
        return masked[4:0];
    endfunction

    function automatic logic [7:0] code_to_ascii(input letter_t c);
        return ASCII_A_BASE + {3'b000, c};
    endfunction

endpackage

// File: rtl/enigma_out_fifo.sv
// -----------------------------------------------------------------------------
// enigma_out_fifo
// Synchronous show-ahead byte FIFO. The head entry is presented on 'head'
// whenever 'not_empty' is high; 'pop' consumes it on the clock edge.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   head       : current head byte, forced to 0 while empty
//   not_empty  : at least one entry stored
//   free       : number of unused entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module enigma_out_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A pop on an empty FIFO is dropped even if a push happens in the same
    // cycle; the pushed byte becomes visible on the following cycle.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop  && (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign not_empty = (count != '0);
    assign head      = not_empty ? mem[rd_ptr] : 8'h00;
    assign free      = CW'(DEPTH) - count;

endmodule

// File: rtl/enigma_stream_driver.sv
// -----------------------------------------------------------------------------
// enigma_stream_driver
// Host-side initiator for the enigma core. Takes an ASCII byte stream,
// sends letters (as 1..26 codes) to the core one at a time, converts each
// enciphered code back to uppercase ASCII and queues it in an output FIFO.
// Non-letters bypass the core and are queued unchanged.
//
// Parameters:
//   DEPTH   : output FIFO entries (power of two, >= 4)
//   TIMEOUT : cycles to wait for the core's result before emitting '?'
//
// Optional build macro:
//   GROUP5_EN : insert a space after every 5 enciphered letters (timeouts
//               included) via an extra GAP state; input then needs >= 2
//               free FIFO slots so the letter and its space always fit.
//
// Ports:
//   clk_in, rst_in                       : clock, sync active-high reset
//   cfg_rotor_select/initial, cfg_valid_in, cfg_ready_out : config request
//   byte_in, byte_valid_in, byte_ready_out                 : ASCII input
//   byte_out, byte_valid_out, byte_ready_in                : ASCII output
//   enig_rotor_select/initial, enig_rotor_valid            : config to core
//   enig_data, enig_data_valid, enig_ready                 : letter to core
//   enig_result, enig_result_valid                         : core result
//   error                                : sticky timeout flag
// -----------------------------------------------------------------------------
module enigma_stream_driver
    import enigma_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [8:0]  cfg_rotor_select,
    input  logic [14:0] cfg_rotor_initial,
    input  logic        cfg_valid_in,
    output logic        cfg_ready_out,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic [8:0]  enig_rotor_select,
    output logic [14:0] enig_rotor_initial,
    output logic        enig_rotor_valid,
    output logic [4:0]  enig_data,
    output logic        enig_data_valid,
    input  logic        enig_ready,
    input  logic [4:0]  enig_result,
    input  logic        enig_result_valid,
    output logic        error
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef GROUP5_EN
    localparam logic [CW-1:0] NEED_FREE = CW'(2);
`else
    localparam logic [CW-1:0] NEED_FREE = CW'(1);
`endif

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [CW-1:0] fifo_free;
    logic          fifo_push;
    logic [7:0]    fifo_din;
    logic          fifo_pop;
    logic          byte_take;
    logic          timed_out;
    logic          letter_done;
    logic          cfg_take;

`ifdef GROUP5_EN
    logic [2:0]    grp_cnt;
`endif

    // Handshake decodes. A pending config request blocks byte acceptance so
    // valid&ready on the byte port always means the byte was taken.
    assign cfg_ready_out    = (state == ST_UNCONF) || (state == ST_IDLE);
    assign cfg_take         = cfg_valid_in && cfg_ready_out;
    assign byte_ready_out   = (state == ST_IDLE) && !cfg_valid_in &&
                              (fifo_free >= NEED_FREE);
    assign byte_take        = byte_valid_in && byte_ready_out;
    assign enig_rotor_valid = (state == ST_CONFIG);
    assign enig_data_valid  = (state == ST_SEND) && enig_ready;
    assign timed_out        = (state == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT));
    assign letter_done      = (state == ST_WAIT) && (enig_result_valid || timed_out);
    assign fifo_pop         = byte_ready_in && byte_valid_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= ST_UNCONF;
            enig_rotor_select  <= '0;
            enig_rotor_initial <= '0;
            enig_data          <= '0;
            error              <= 1'b0;
            tmo_cnt            <= '0;
`ifdef GROUP5_EN
            grp_cnt            <= '0;
`endif
        end else begin
            // Config is only sampled in UNCONF/IDLE, never mid-letter.
            if (cfg_take) begin
                enig_rotor_select  <= cfg_rotor_select;
                enig_rotor_initial <= cfg_rotor_initial;
            end
            case (state)
                ST_UNCONF: begin
                    if (cfg_take) begin
                        state <= ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    error   <= 1'b0;
                    tmo_cnt <= '0;
`ifdef GROUP5_EN
                    grp_cnt <= '0;
`endif
                    state   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cfg_take) begin
                        state <= ST_CONFIG;
                    end else if (byte_take && is_letter(byte_in)) begin
                        enig_data <= letter_code(byte_in);
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (enig_ready) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (letter_done) begin
                        // A result on the timeout cycle still wins.
                        if (!enig_result_valid) begin
                            error <= 1'b1;
                        end
`ifdef GROUP5_EN
                        if (grp_cnt == 3'(GROUP_LEN - 1)) begin
                            grp_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            grp_cnt <= grp_cnt + 3'd1;
                            state   <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_UNCONF;
                end
            endcase
        end
    end

    // At most one FIFO write source is active per state.
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = byte_in;
        case (state)
            ST_IDLE: begin
                if (byte_take && !is_letter(byte_in)) begin
                    fifo_push = 1'b1;
                end
            end
            ST_WAIT: begin
                if (enig_result_valid) begin
                    fifo_push = 1'b1;
                    fifo_din  = code_to_ascii(enig_result);
                end else if (timed_out) begin
                    fifo_push = 1'b1;
                    fifo_din  = ASCII_QMARK;
                end
            end
            ST_GAP: begin
                fifo_push = 1'b1;
                fifo_din  = ASCII_SPACE;
            end
            default: begin
                fifo_push = 1'b0;
            end
        endcase
    end

    enigma_out_fifo #(
        .DEPTH(DEPTH)
    ) u_out_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (fifo_push),
        .din       (fifo_din),
        .pop       (fifo_pop),
        .head      (byte_out),
        .not_empty (byte_valid_out),
        .free      (fifo_free)
    );

endmodule

// File: tb/tb_enigma_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_enigma_stream_driver
// Directed bench for enigma_stream_driver with a scoreboard of expected
// output bytes and a small core stub (echo / fixed 5 / silent modes).
// -----------------------------------------------------------------------------
module tb_enigma_stream_driver;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 2;

    localparam int STUB_ECHO   = 0;
    localparam int STUB_FIXED5 = 1;
    localparam int STUB_NONE   = 2;

`ifdef GROUP5_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [8:0]  cfg_rotor_select;
    logic [14:0] cfg_rotor_initial;
    logic        cfg_valid_in;
    logic        cfg_ready_out;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ready_in;
    logic [8:0]  enig_rotor_select;
    logic [14:0] enig_rotor_initial;
    logic        enig_rotor_valid;
    logic [4:0]  enig_data;
    logic        enig_data_valid;
    logic        enig_ready;
    logic [4:0]  enig_result;
    logic        enig_result_valid;
    logic        error;

    always #5 clk_in = ~clk_in;

    enigma_stream_driver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .cfg_rotor_select   (cfg_rotor_select),
        .cfg_rotor_initial  (cfg_rotor_initial),
        .cfg_valid_in       (cfg_valid_in),
        .cfg_ready_out      (cfg_ready_out),
        .byte_in            (byte_in),
        .byte_valid_in      (byte_valid_in),
        .byte_ready_out     (byte_ready_out),
        .byte_out           (byte_out),
        .byte_valid_out     (byte_valid_out),
        .byte_ready_in      (byte_ready_in),
        .enig_rotor_select  (enig_rotor_select),
        .enig_rotor_initial (enig_rotor_initial),
        .enig_rotor_valid   (enig_rotor_valid),
        .enig_data          (enig_data),
        .enig_data_valid    (enig_data_valid),
        .enig_ready         (enig_ready),
        .enig_result        (enig_result),
        .enig_result_valid  (enig_result_valid),
        .error              (error)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         cycle      = 0;
    int         stub_mode  = STUB_ECHO;
    int         pend       = 0;
    logic [4:0] pend_code  = 5'd0;
    int         data_pulses  = 0;
    int         rotor_pulses = 0;
    logic [4:0] last_data  = 5'd0;
    int         send_cycle = 0;
    int         accept_cycle = 0;
    int         first_vld_cycle = -1;
    bit         byte_acc = 1'b0;
    bit         cfg_acc  = 1'b0;
    logic [7:0] exp_q[$];
`ifdef GROUP5_EN
    int         grp = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update stub after the rising edge.
    task automatic tick();
        @(negedge clk_in);
        if (!rst_in) begin
            if (enig_data_valid) begin
                data_pulses++;
                last_data  = enig_data;
                send_cycle = cycle;
                if (stub_mode != STUB_NONE) begin
                    pend      = LAT;
                    pend_code = (stub_mode == STUB_FIXED5) ? 5'd5 : enig_data;
                end
            end
            if (enig_rotor_valid) rotor_pulses++;
            if (byte_valid_in && byte_ready_out) begin
                byte_acc     = 1'b1;
                accept_cycle = cycle;
            end
            if (cfg_valid_in && cfg_ready_out) cfg_acc = 1'b1;
            if (byte_valid_out && first_vld_cycle < 0) first_vld_cycle = cycle;
            if (byte_valid_out && byte_ready_in) begin
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL sb_extra observed=%0h expected=none", byte_out);
                end
                if (exp_q.size() != 0) check("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
            end
        end
        @(posedge clk_in);
        #1;
        cycle++;
        enig_result_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                enig_result       = pend_code;
                enig_result_valid = 1'b1;
            end
        end
    endtask

    function automatic bit tb_is_letter(input logic [7:0] b);
        return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
    endfunction

    task automatic model_group_reset();
`ifdef GROUP5_EN
        grp = 0;
`endif
    endtask

    task automatic expect_byte(input logic [7:0] b);
        if (tb_is_letter(b)) begin
            if (stub_mode == STUB_ECHO)
                exp_q.push_back((b >= "a") ? b - 8'h20 : b);
            else if (stub_mode == STUB_FIXED5)
                exp_q.push_back("E");
            else
                exp_q.push_back("?");
`ifdef GROUP5_EN
            grp++;
            if (grp == 5) begin
                exp_q.push_back(" ");
                grp = 0;
            end
`endif
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit track);
        byte_acc      = 1'b0;
        byte_in       = b;
        byte_valid_in = 1'b1;
        for (int i = 0; i < 100 && !byte_acc; i++) tick();
        byte_valid_in = 1'b0;
        check("byte_accept", {31'd0, byte_acc}, 32'd1);
        if (byte_acc && track) expect_byte(b);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_config(input logic [8:0] sel, input logic [14:0] init);
        int r0;
        r0 = rotor_pulses;
        cfg_rotor_select  = sel;
        cfg_rotor_initial = init;
        cfg_acc           = 1'b0;
        cfg_valid_in      = 1'b1;
        for (int i = 0; i < 100 && !cfg_acc; i++) tick();
        cfg_valid_in = 1'b0;
        repeat (3) tick();
        check("cfg_accept", {31'd0, cfg_acc}, 32'd1);
        check("rotor_pulse", rotor_pulses - r0, 32'd1);
        check("rotor_sel", {23'd0, enig_rotor_select}, {23'd0, sel});
        check("rotor_init", {17'd0, enig_rotor_initial}, {17'd0, init});
        model_group_reset();
    endtask

    initial begin
        int d0;
        rst_in            = 1'b1;
        cfg_rotor_select  = '0;
        cfg_rotor_initial = '0;
        cfg_valid_in      = 1'b0;
        byte_in           = '0;
        byte_valid_in     = 1'b0;
        byte_ready_in     = 1'b1;
        enig_ready        = 1'b1;
        enig_result       = '0;
        enig_result_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cfg_ready", {31'd0, cfg_ready_out}, 32'd1);
        check("rst_byte_ready", {31'd0, byte_ready_out}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid_out}, 32'd0);
        check("rst_byte_out", {24'd0, byte_out}, 32'd0);
        check("rst_rotor_valid", {31'd0, enig_rotor_valid}, 32'd0);
        check("rst_data_valid", {31'd0, enig_data_valid}, 32'd0);
        check("rst_data", {27'd0, enig_data}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst_in = 1'b0;
        repeat (2) tick();
        check("unconf_byte_ready", {31'd0, byte_ready_out}, 32'd0);

        // Config and first letter through a fixed-result stub
        stub_mode = STUB_FIXED5;
        do_config({3'd1, 3'd2, 3'd3}, 15'd0);
        d0 = data_pulses;
        first_vld_cycle = -1;
        send_byte("A", 1'b1);
        drain(50);
        check("A_pulses", data_pulses - d0, 32'd1);
        check("A_code", {27'd0, last_data}, 32'd1);
        check("A_latency", first_vld_cycle - accept_cycle, 32'd1 + LAT + 1);

        // Echo stub; SEND must hold while the core is not ready
        stub_mode  = STUB_ECHO;
        enig_ready = 1'b0;
        d0 = data_pulses;
        send_byte("b", 1'b1);
        repeat (4) tick();
        check("send_hold", data_pulses - d0, 32'd0);
        enig_ready = 1'b1;
        drain(50);
        check("b_code", {27'd0, last_data}, 32'd2);
        send_byte("z", 1'b1);
        drain(50);
        check("z_code", {27'd0, last_data}, 32'd26);

        // Non-letters bypass the core
        d0 = data_pulses;
        send_byte(" ", 1'b1);
        send_byte("7", 1'b1);
        send_byte(".", 1'b1);
        drain(50);
        check("nonletter_pulses", data_pulses - d0, 32'd0);

        // Back-pressure: fill the FIFO, then release
        byte_ready_in = 1'b0;
        for (int i = 0; i < 2 * DEPTH && (DEPTH - exp_q.size()) >= NEED; i++)
            send_byte(8'(8'h61 + i), 1'b1);
        repeat (6) tick();
        check("full_ready", {31'd0, byte_ready_out}, 32'd0);
        check("full_valid", {31'd0, byte_valid_out}, 32'd1);
        byte_acc      = 1'b0;
        byte_in       = "x";
        byte_valid_in = 1'b1;
        repeat (5) tick();
        byte_valid_in = 1'b0;
        check("full_block", {31'd0, byte_acc}, 32'd0);
        byte_ready_in = 1'b1;
        drain(100);

        // Core never answers: '?' after the timeout, sticky error
        stub_mode = STUB_NONE;
        first_vld_cycle = -1;
        send_byte("Q", 1'b1);
        drain(200);
        check("tmo_latency", first_vld_cycle - send_cycle, 32'(TIMEOUT + 2));
        check("tmo_error", {31'd0, error}, 32'd1);
        enig_result       = 5'd3;
        enig_result_valid = 1'b1;
        repeat (4) tick();
        check("late_ignored", {31'd0, byte_valid_out}, 32'd0);
        do_config({3'd4, 3'd3, 3'd2}, {5'd3, 5'd7, 5'd25});
        check("cfg_clears_error", {31'd0, error}, 32'd0);

        // Reset while waiting for the core, then a stale result
        send_byte("K", 1'b0);
        repeat (4) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        enig_result       = 5'd4;
        enig_result_valid = 1'b1;
        repeat (4) tick();
        check("wrst_valid", {31'd0, byte_valid_out}, 32'd0);
        check("wrst_cfg_ready", {31'd0, cfg_ready_out}, 32'd1);
        check("wrst_byte_ready", {31'd0, byte_ready_out}, 32'd0);
        check("wrst_error", {31'd0, error}, 32'd0);
        check("wrst_q", exp_q.size(), 32'd0);

        // Ten letters back to back
        stub_mode = STUB_ECHO;
        do_config({3'd1, 3'd2, 3'd3}, 15'd0);
        d0 = data_pulses;
        for (int i = 0; i < 10; i++)
            send_byte((i % 2 == 0) ? 8'(8'h43 + i) : 8'(8'h63 + i), 1'b1);
        drain(300);
        check("ten_pulses", data_pulses - d0, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
